// File: rtl/cpu_irq_sequencer.sv
// cpu_irq_sequencer: CPU-side interrupt acceptor.
// Acks the controller, fetches the handler vector, dispatches to core.
module cpu_irq_sequencer #(
  parameter logic [23:0] VECTOR_BASE = 24'h000000,
  parameter bit          NMI_ENABLE  = 1'b1,
  parameter logic [7:0]  NMI_VECTOR  = 8'h02
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  cpu_irq,
  input  logic [1:0]  irq_mask,
  input  logic        insn_boundary,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_grant,
  input  logic        dispatch_ready,
  output logic        cpu_iack,
  output logic        bus_read,
  output logic [23:0] bus_address_out,
  output logic        dispatch_valid,
  output logic [15:0] dispatch_pc,
  output logic [1:0]  dispatch_level,
  output logic [7:0]  dispatch_vector,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_VEC_LO,
    S_VEC_HI,
    S_DISPATCH
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        nmi_prev_q;
  logic        nmi_pend_q;
  logic        kind_nmi_q;
  logic [1:0]  level_q;
  logic [7:0]  vector_q;
  logic [15:0] pc_q;

  logic [1:0]  irq_lvl;
  logic        nmi_rise;
  logic        nmi_clr;
  logic        go;
  logic        withdrawn;
  logic [23:0] addr_lo;
  logic [23:0] addr_hi;

  // Highest pending maskable priority, 0 when none
  always_comb begin
    irq_lvl = 2'd0;
    unique case (1'b1)
      cpu_irq[3]: irq_lvl = 2'd3;
      cpu_irq[2]: irq_lvl = 2'd2;
      cpu_irq[1]: irq_lvl = 2'd1;
      default:    irq_lvl = 2'd0;
    endcase
  end

  assign nmi_rise  = NMI_ENABLE && cpu_irq[0]
                     && !nmi_prev_q;
  assign nmi_clr   = (state_q == S_ACK)
                     && kind_nmi_q;
  assign go        = insn_boundary
                     && (nmi_pend_q || irq_lvl > irq_mask);
  assign withdrawn = (cpu_irq[3:1] == 3'b000);
  assign addr_lo   = VECTOR_BASE + {16'h0000, vector_q};
  assign addr_hi   = addr_lo + 24'd1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NMI edge detector; pending survives until its ACK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= cpu_irq[0];
      nmi_pend_q <= (nmi_pend_q && !nmi_clr)
                    || nmi_rise;
    end
  end

  // Sequence context: kind, level, vector, handler pc
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kind_nmi_q <= 1'b0;
      level_q    <= 2'd0;
      vector_q   <= 8'h00;
      pc_q       <= 16'h0000;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            kind_nmi_q <= nmi_pend_q;
            level_q    <= nmi_pend_q ? 2'd3 : irq_lvl;
          end
        end
        S_ACK: begin
          vector_q <= kind_nmi_q ? NMI_VECTOR
                                 : bus_data_in;
        end
        S_VEC_LO: begin
          if (bus_grant) pc_q[7:0] <= bus_data_in;
        end
        S_VEC_HI: begin
          if (bus_grant) pc_q[15:8] <= bus_data_in;
        end
        default: ;
      endcase
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d         = state_q;
    cpu_iack        = 1'b0;
    bus_read        = 1'b0;
    bus_address_out = 24'h000000;
    dispatch_valid  = 1'b0;
    dispatch_pc     = 16'h0000;
    dispatch_level  = 2'd0;
    dispatch_vector = 8'h00;
    busy            = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_ACK;
      end
      S_ACK: begin
        cpu_iack = !kind_nmi_q;
        if (!kind_nmi_q && withdrawn)
          state_d = S_IDLE;
        else
          state_d = S_VEC_LO;
      end
      S_VEC_LO: begin
        bus_read        = 1'b1;
        bus_address_out = addr_lo;
        if (bus_grant) state_d = S_VEC_HI;
      end
      S_VEC_HI: begin
        bus_read        = 1'b1;
        bus_address_out = addr_hi;
        if (bus_grant) state_d = S_DISPATCH;
      end
      S_DISPATCH: begin
        dispatch_valid  = 1'b1;
        dispatch_pc     = pc_q;
        dispatch_level  = level_q;
        dispatch_vector = vector_q;
        if (dispatch_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_irq_sequencer.sv
// tb_cpu_irq_sequencer: directed bench for cpu_irq_sequencer.
// Bus is a small table model; checks sampled on negedge.
module tb_cpu_irq_sequencer;

  logic        clk;
  logic        reset_n;
  logic [3:0]  cpu_irq;
  logic [1:0]  irq_mask;
  logic        insn_boundary;
  logic [7:0]  bus_data_in;
  logic        bus_grant;
  logic        dispatch_ready;
  logic        cpu_iack;
  logic        bus_read;
  logic [23:0] bus_address_out;
  logic        dispatch_valid;
  logic [15:0] dispatch_pc;
  logic [1:0]  dispatch_level;
  logic [7:0]  dispatch_vector;
  logic        busy;

  logic [7:0]  mem [256];
  logic [7:0]  ack_vec;
  int          n_chk;
  int          n_err;

  cpu_irq_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cpu_irq         (cpu_irq),
    .irq_mask        (irq_mask),
    .insn_boundary   (insn_boundary),
    .bus_data_in     (bus_data_in),
    .bus_grant       (bus_grant),
    .dispatch_ready  (dispatch_ready),
    .cpu_iack        (cpu_iack),
    .bus_read        (bus_read),
    .bus_address_out (bus_address_out),
    .dispatch_valid  (dispatch_valid),
    .dispatch_pc     (dispatch_pc),
    .dispatch_level  (dispatch_level),
    .dispatch_vector (dispatch_vector),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus model: table read while reading, else vector byte
  always_comb begin
    bus_data_in = ack_vec;
    if (bus_read) bus_data_in = mem[bus_address_out[7:0]];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_outs(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".iack"}, 32'(cpu_iack), 32'd0);
    check({tag, ".rd"}, 32'(bus_read), 32'd0);
    check({tag, ".addr"}, 32'(bus_address_out), 32'd0);
    check({tag, ".val"}, 32'(dispatch_valid), 32'd0);
    check({tag, ".pc"}, 32'(dispatch_pc), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h1C] = 8'h34;
    mem[8'h1D] = 8'h12;
    mem[8'h02] = 8'hCD;
    mem[8'h03] = 8'hAB;
    ack_vec        = 8'h1C;
    reset_n        = 1'b0;
    cpu_irq        = 4'b0000;
    irq_mask       = 2'd1;
    insn_boundary  = 1'b0;
    bus_grant      = 1'b1;
    dispatch_ready = 1'b1;
    step();
    idle_outs("rst");
    reset_n = 1'b1;
    step();

    // 1: level-2 request, zero wait states
    cpu_irq = 4'b0100;
    insn_boundary = 1'b1;
    step();
    insn_boundary = 1'b0;
    check("t1.iack", 32'(cpu_iack), 32'd1);
    check("t1.busy", 32'(busy), 32'd1);
    step();
    check("t1.rd_lo", 32'(bus_read), 32'd1);
    check("t1.a_lo", 32'(bus_address_out), 32'h1C);
    check("t1.iack0", 32'(cpu_iack), 32'd0);
    step();
    check("t1.a_hi", 32'(bus_address_out), 32'h1D);
    step();
    check("t1.val", 32'(dispatch_valid), 32'd1);
    check("t1.pc", 32'(dispatch_pc), 32'h1234);
    check("t1.lvl", 32'(dispatch_level), 32'd2);
    check("t1.vec", 32'(dispatch_vector), 32'h1C);
    cpu_irq = 4'b0000;
    step();
    check("t1.done", 32'(busy), 32'd0);

    // 2: level 1 blocked by mask 1, then mask 0
    cpu_irq = 4'b0010;
    irq_mask = 2'd1;
    insn_boundary = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2.blk_busy", 32'(busy), 32'd0);
      check("t2.blk_iack", 32'(cpu_iack), 32'd0);
    end
    irq_mask = 2'd0;
    step();
    insn_boundary = 1'b0;
    check("t2.iack", 32'(cpu_iack), 32'd1);
    step();
    step();
    step();
    check("t2.val", 32'(dispatch_valid), 32'd1);
    check("t2.lvl", 32'(dispatch_level), 32'd1);
    cpu_irq = 4'b0000;
    step();

    // 3: NMI edge during a level-3 sequence
    cpu_irq = 4'b1000;
    insn_boundary = 1'b1;
    step();
    insn_boundary = 1'b0;
    cpu_irq = 4'b1001;
    check("t3.iack", 32'(cpu_iack), 32'd1);
    step();
    step();
    step();
    check("t3.val1", 32'(dispatch_valid), 32'd1);
    check("t3.lvl1", 32'(dispatch_level), 32'd3);
    check("t3.vec1", 32'(dispatch_vector), 32'h1C);
    cpu_irq = 4'b0000;
    insn_boundary = 1'b1;
    step();
    check("t3.gap", 32'(busy), 32'd0);
    step();
    insn_boundary = 1'b0;
    check("t3.nmi_busy", 32'(busy), 32'd1);
    check("t3.nmi_iack", 32'(cpu_iack), 32'd0);
    step();
    check("t3.nmi_a", 32'(bus_address_out), 32'h02);
    step();
    step();
    check("t3.val2", 32'(dispatch_valid), 32'd1);
    check("t3.vec2", 32'(dispatch_vector), 32'h02);
    check("t3.lvl2", 32'(dispatch_level), 32'd3);
    check("t3.pc2", 32'(dispatch_pc), 32'hABCD);
    step();
    insn_boundary = 1'b1;
    step();
    check("t3.clr", 32'(busy), 32'd0);
    insn_boundary = 1'b0;

    // 4: request withdrawn during ACK
    cpu_irq = 4'b1000;
    insn_boundary = 1'b1;
    step();
    cpu_irq = 4'b0000;
    insn_boundary = 1'b0;
    check("t4.ack", 32'(busy), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      idle_outs("t4");
    end

    // 5: grant and ready stalls
    cpu_irq = 4'b0100;
    irq_mask = 2'd0;
    bus_grant = 1'b0;
    insn_boundary = 1'b1;
    step();
    insn_boundary = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5.rd", 32'(bus_read), 32'd1);
      check("t5.a_lo", 32'(bus_address_out), 32'h1C);
    end
    step();
    check("t5.a_lo4", 32'(bus_address_out), 32'h1C);
    bus_grant = 1'b1;
    dispatch_ready = 1'b0;
    step();
    check("t5.a_hi", 32'(bus_address_out), 32'h1D);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5.val", 32'(dispatch_valid), 32'd1);
      check("t5.pc", 32'(dispatch_pc), 32'h1234);
      check("t5.lvl", 32'(dispatch_level), 32'd2);
    end
    dispatch_ready = 1'b1;
    cpu_irq = 4'b0000;
    step();
    check("t5.done", 32'(busy), 32'd0);

    // 6: reset in VEC_HI, pending NMI dropped
    cpu_irq = 4'b1000;
    insn_boundary = 1'b1;
    step();
    insn_boundary = 1'b0;
    cpu_irq = 4'b1001;
    step();
    step();
    check("t6.in_hi", 32'(bus_address_out), 32'h1D);
    reset_n = 1'b0;
    #1;
    idle_outs("t6.rst");
    cpu_irq = 4'b0000;
    step();
    reset_n = 1'b1;
    insn_boundary = 1'b1;
    step();
    step();
    check("t6.nmi_gone", 32'(busy), 32'd0);
    cpu_irq = 4'b0100;
    irq_mask = 2'd1;
    step();
    insn_boundary = 1'b0;
    check("t6.iack", 32'(cpu_iack), 32'd1);
    step();
    step();
    step();
    check("t6.val", 32'(dispatch_valid), 32'd1);
    check("t6.pc", 32'(dispatch_pc), 32'h1234);
    check("t6.lvl", 32'(dispatch_level), 32'd2);
    cpu_irq = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
